rc5_dec_16bit: RTL and testbench
================================

// Module: rc5_dec_16bit
// PURPOSE
//  Single-round RC5 decryptor, 16-bit block (two 8-bit halves A=c[15:8], B=c[7:0]).
//  Inverse of rc5_enc_16bit with the same key schedule: recovers plaintext p from ciphertext c.
//  Multi-cycle FSM with start/done handshake, one half-operation per clock.
//  Sits on the receive side of the link, downstream of the ciphertext source.
// PARAMETERS
//  S0  8'h20  key word, pre-whitening for A
//  S1  8'h10  key word, pre-whitening for B
//  S2  8'h0F  key word, round key for A
//  S3  8'hFF  key word, round key for B
// PORTS
//  clock      in   1   rising-edge clock
//  reset      in   1   synchronous, active-low reset
//  dec_start  in   1   level request; sampled in IDLE, must be held high until dec_done
//  c          in   16  ciphertext, captured on the cycle dec_start is seen in IDLE
//  p          out  16  recovered plaintext, registered, valid while dec_done=1
//  dec_done   out  1   result-valid flag
//  busy       out  1   high in RND_B, RND_A and POST
// BEHAVIOUR
//  Reset (reset=0 at a clock edge): state=IDLE, A=B=0, p=16'h0000, dec_done=0, busy=0.
//  - Reset has priority over every other input and aborts any operation in flight.
//  Arithmetic is 8-bit mod 256; subtraction wraps.
//  ROR(x,n) is an 8-bit rotate right by n[2:0]; n=0 returns x unchanged, with no shift-by-8 artefact.
//  States (3-bit encoding):
//  - IDLE (000): if dec_start=1 then A<=c[15:8], B<=c[7:0], go to RND_B; else hold.
//  - RND_B (001): B <= ROR(B-S3, A[2:0]) ^ A; go to RND_A.
//  - RND_A (010): A <= ROR(A-S2, B[2:0]) ^ B, using B updated in RND_B; go to POST.
//  - POST (011): p <= {A-S0, B-S1}; dec_done<=1; go to DONE.
//  - DONE (100): hold p and dec_done while dec_start=1.
//      On dec_start=0: dec_done<=0 and go to IDLE; p retains its value.
//  - Unused encodings: go to IDLE with dec_done=0.
//  Latency: capture at edge k; p and dec_done are valid after edge k+3.
//  - dec_done stays high for at least 1 cycle.
//  - Minimum start-to-start spacing: 5 cycles (capture, 3 compute, DONE exit).
//  Abort: dec_start=0 during RND_B, RND_A or POST -> IDLE next edge.
//  - On abort, dec_done stays 0 and p is unchanged.
//  - The abort check has priority over the state action.
//  c changing after capture has no effect on the result.
//  A new request is accepted only after dec_start has returned low and the FSM is back in IDLE.
// TESTING
//  1. Reset, then c=16'h3F96 with dec_start held -> dec_done=1 after 3 cycles, p=16'h0000.
//  2. c=16'h768B -> p=16'h1234 (rotations by 6 and 4).
//  3. c=16'h170B -> p=16'hFFFF (mod-256 wrap on every subtraction, rotate by 7).
//  4. Round-trip: feed random p through rc5_enc_16bit and the c into this block (>=1000 vectors)
//     -> recovered p equals the original.
//  5. Drop dec_start in RND_A -> IDLE next edge, dec_done never asserts, p keeps its old value.
//     Then restart with c=16'h3F96 -> p=16'h0000.
//  6. Assert reset=0 during POST -> p=0 and dec_done=0 next edge.
//     Also: hold dec_start in DONE for 4 cycles -> p/dec_done stable; release -> dec_done=0 next edge.

Source files
------------

// File: rtl/rc5_dec_16bit.sv
// Single-round RC5 decryptor for a 16-bit block (two 8-bit halves).
// One half-operation per clock with a level start / done handshake.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | waiting for dec_start, ciphertext captured on acceptance
//  RND_B  | undo the B half-round using the current A
//  RND_A  | undo the A half-round using the freshly recovered B
//  POST   | remove the pre-whitening keys and register the plaintext
//  DONE   | hold the result until dec_start is released
module rc5_dec_16bit #(
    parameter logic [7:0] S0 = 8'h20,
    parameter logic [7:0] S1 = 8'h10,
    parameter logic [7:0] S2 = 8'h0F,
    parameter logic [7:0] S3 = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dec_start,
    input  logic [15:0] c,
    output logic [15:0] p,
    output logic        dec_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        RND_B = 3'b001,
        RND_A = 3'b010,
        POST  = 3'b011,
        DONE  = 3'b100
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  a_next;
    logic [7:0]  b_next;
    logic [15:0] p_next;
    logic        done_next;

    // Rotating a doubled copy keeps n=0 an identity with no shift-by-8 edge case.
    function automatic logic [7:0] ror8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] doubled;
        doubled = {x, x} >> n;
        return doubled[7:0];
    endfunction

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            a        <= 8'h00;
            b        <= 8'h00;
            p        <= 16'h0000;
            dec_done <= 1'b0;
        end else begin
            state    <= state_next;
            a        <= a_next;
            b        <= b_next;
            p        <= p_next;
            dec_done <= done_next;
        end
    end

    // Next-state and datapath updates; an early release of dec_start aborts
    // the computation before any state action takes effect.
    always_comb begin
        state_next = state;
        a_next     = a;
        b_next     = b;
        p_next     = p;
        done_next  = dec_done;
        case (state)
            IDLE: begin
                done_next = 1'b0;
                if (dec_start) begin
                    a_next     = c[15:8];
                    b_next     = c[7:0];
                    state_next = RND_B;
                end
            end
            RND_B: begin
                if (!dec_start) begin
                    state_next = IDLE;
                end else begin
                    b_next     = ror8(b - S3, a[2:0]) ^ a;
                    state_next = RND_A;
                end
            end
            RND_A: begin
                if (!dec_start) begin
                    state_next = IDLE;
                end else begin
                    a_next     = ror8(a - S2, b[2:0]) ^ b;
                    state_next = POST;
                end
            end
            POST: begin
                if (!dec_start) begin
                    state_next = IDLE;
                end else begin
                    p_next     = {a - S0, b - S1};
                    done_next  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!dec_start) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                done_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Busy covers the three compute states only.
    always_comb begin
        busy = (state == RND_B) || (state == RND_A) || (state == POST);
    end

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// Directed bench for rc5_dec_16bit: hand-computed vectors, abort, reset
// during compute, DONE hold, and a round trip through a reference encryptor.
module tb_rc5_dec_16bit;

    localparam logic [7:0] K0 = 8'h20;
    localparam logic [7:0] K1 = 8'h10;
    localparam logic [7:0] K2 = 8'h0F;
    localparam logic [7:0] K3 = 8'hFF;

    logic        clock;
    logic        reset;
    logic        dec_start;
    logic [15:0] c;
    logic [15:0] p;
    logic        dec_done;
    logic        busy;

    int n_compared;
    int n_mismatched;

    rc5_dec_16bit dut (
        .clock    (clock),
        .reset    (reset),
        .dec_start(dec_start),
        .c        (c),
        .p        (p),
        .dec_done (dec_done),
        .busy     (busy)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Rotate left one bit at a time, a different formulation from the RTL.
    function automatic logic [7:0] rol8(input logic [7:0] x, input logic [2:0] n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < int'(n); i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [15:0] enc(input logic [15:0] pt);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = pt[15:8] + K0;
        eb = pt[7:0] + K1;
        ea = rol8(ea ^ eb, eb[2:0]) + K2;
        eb = rol8(eb ^ ea, ea[2:0]) + K3;
        return {ea, eb};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full decrypt with latency check; optionally scrambles c after capture.
    task automatic run_dec(input string tag, input logic [15:0] ct, input logic [15:0] exp_p,
                           input bit check_lat);
        int n;
        dec_start = 1'b1;
        c = ct;
        tick();
        c = 16'($urandom);
        if (check_lat) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 1;
        while (!dec_done && n < 10) begin
            tick();
            n++;
        end
        if (check_lat) check({tag, "_lat"}, n, 4);
        check({tag, "_done"}, {31'd0, dec_done}, 32'd1);
        check({tag, "_p"}, {16'd0, p}, {16'd0, exp_p});
        dec_start = 1'b0;
        tick();
        if (check_lat) check({tag, "_release"}, {31'd0, dec_done}, 32'd0);
    endtask

    initial begin
        logic [15:0] pt;
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b0;
        dec_start = 1'b0;
        c         = 16'h0000;
        tick();
        tick();
        check("rst_p", {16'd0, p}, 32'h0);
        check("rst_done", {31'd0, dec_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        tick();

        run_dec("v1", 16'h3F96, 16'h0000, 1'b1);
        run_dec("v2", 16'h768B, 16'h1234, 1'b1);
        run_dec("v3", 16'h170B, 16'hFFFF, 1'b1);

        // Abort in RND_A: p must keep FFFF.
        dec_start = 1'b1;
        c = 16'h768B;
        tick();
        tick();
        dec_start = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, dec_done}, 32'd0);
        check("abort_p", {16'd0, p}, 32'h0000FFFF);
        tick();
        tick();
        check("abort_done_late", {31'd0, dec_done}, 32'd0);
        run_dec("restart", 16'h3F96, 16'h0000, 1'b1);

        // Reset during POST.
        run_dec("pre_rst", 16'h768B, 16'h1234, 1'b0);
        dec_start = 1'b1;
        c = 16'h170B;
        tick();
        tick();
        tick();
        check("post_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        check("rst_post_p", {16'd0, p}, 32'h0);
        check("rst_post_done", {31'd0, dec_done}, 32'd0);
        reset = 1'b1;
        dec_start = 1'b0;
        tick();

        // Hold in DONE for 4 cycles, then release.
        dec_start = 1'b1;
        c = 16'h170B;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            check("hold_done", {31'd0, dec_done}, 32'd1);
            check("hold_p", {16'd0, p}, 32'h0000FFFF);
            check("hold_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        dec_start = 1'b0;
        tick();
        check("hold_release_done", {31'd0, dec_done}, 32'd0);
        check("hold_release_p", {16'd0, p}, 32'h0000FFFF);

        // Round trip through the reference encryptor.
        for (int i = 0; i < 1000; i++) begin
            pt = 16'($urandom);
            run_dec("roundtrip", enc(pt), pt, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
